equiv_compare_monitor: RTL and testbench

Downstream consumer of the Behavioral/Structural equivalence bench. It takes each applied 4-bit input vector and the {W,V} outputs of both implementations, waits a programmable settle time, then compares the two implementations. It keeps a vector count, a mismatch count, sticky pass/overrun flags and a capture of the first failing vector, and signals completion after a fixed number of vectors. The bench instantiates it beside the two UUTs and reads the results at the end of the run, replacing manual waveform inspection.

---
 rtl/equiv_mon_pkg.sv | 25 ++
 rtl/settle_timer.sv | 41 ++++
 rtl/equiv_compare_monitor.sv | 150 +++++++++++++++
 tb/tb_equiv_compare_monitor.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/equiv_mon_pkg.sv
// Shared types for the equivalence compare monitor.
//   state_t        : monitor FSM states
//   wv_t / vec_t   : UUT {W,V} output and applied {A,B,C,D} vector
//   fail_capture_t : snapshot taken at the first failing compare
package equiv_mon_pkg;

    localparam int unsigned TIMER_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        COMPARE = 2'd2,
        DONE    = 2'd3
    } state_t;

    typedef logic [1:0] wv_t;
    typedef logic [3:0] vec_t;

    typedef struct packed {
        vec_t vec;
        wv_t  b;
        wv_t  s;
    } fail_capture_t;

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter used to pace the settle window.
//   clk, rst_n : clock, async active-low reset
//   load       : reload the counter with load_val this cycle
//   load_val   : reload value
//   expired    : registered; high while the count is 1 or 0, i.e. the
//                current cycle is the last one of the window
module settle_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: reload wins, otherwise decrement and stick at zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    // expired is registered from the next count so it lines up with count_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            expired <= 1'b1;
        end else begin
            count_q <= count_d;
            expired <= (count_d <= W'(1));
        end
    end

endmodule

// File: rtl/equiv_compare_monitor.sv
// Compares Behavioral and Structural UUT outputs after a settle delay,
// accumulating counts, sticky flags and the first failing vector.
//   clk, rst_n      : clock, async active-low reset
//   clear           : sync return to IDLE with all results zeroed
//   vec_valid       : strobe, new vector applied to both UUTs
//   vec_in          : applied vector {A,B,C,D}
//   b_wv, s_wv      : Behavioral / Structural {W,V}
//   busy, done      : in SETTLE/COMPARE, in DONE
//   pass, overrun   : sticky no-mismatch-yet, sticky dropped-vector
//   vec_count       : compares performed
//   mismatch_count  : failing compares, saturating
//   first_fail_*    : vector and outputs at the first failing compare
module equiv_compare_monitor
    import equiv_mon_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned NUM_VECTORS   = 10,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             vec_valid,
    input  logic [3:0]       vec_in,
    input  logic [1:0]       b_wv,
    input  logic [1:0]       s_wv,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             overrun,
    output logic [CNT_W-1:0] vec_count,
    output logic [CNT_W-1:0] mismatch_count,
    output logic [3:0]       first_fail_vec,
    output logic [1:0]       first_fail_b,
    output logic [1:0]       first_fail_s
);

    state_t        state_q;
    vec_t          vec_q;
    fail_capture_t ff_q;

    logic differ_c;
    logic last_c;
    logic accept_c;
    logic timer_load_c;
    logic timer_expired;

    // Decode: mismatch (X/Z counts as different), final compare, new vector taken.
    always_comb begin
        differ_c     = (b_wv !== s_wv);
        last_c       = (vec_count == CNT_W'(NUM_VECTORS - 1));
        accept_c     = 1'b0;
        unique case (state_q)
            IDLE, SETTLE: accept_c = vec_valid;
            COMPARE:      accept_c = vec_valid && !last_c;
            default:      accept_c = 1'b0;
        endcase
        timer_load_c = accept_c && !clear;
    end

    settle_timer #(
        .W(TIMER_W)
    ) u_settle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load_c),
        .load_val (TIMER_W'(SETTLE_CYCLES)),
        .expired  (timer_expired)
    );

    // Monitor FSM with registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            vec_q          <= '0;
            ff_q           <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b1;
            overrun        <= 1'b0;
            vec_count      <= '0;
            mismatch_count <= '0;
        end else if (clear) begin
            state_q        <= IDLE;
            vec_q          <= '0;
            ff_q           <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b1;
            overrun        <= 1'b0;
            vec_count      <= '0;
            mismatch_count <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (vec_valid) begin
                        vec_q   <= vec_in;
                        state_q <= SETTLE;
                        busy    <= 1'b1;
                    end
                end
                SETTLE: begin
                    // A fresh strobe restarts the window; the old vector is lost.
                    if (vec_valid) begin
                        vec_q   <= vec_in;
                        overrun <= 1'b1;
                    end else if (timer_expired) begin
                        state_q <= COMPARE;
                    end
                end
                COMPARE: begin
                    vec_count <= vec_count + CNT_W'(1);
                    if (differ_c) begin
                        if (mismatch_count != '1) begin
                            mismatch_count <= mismatch_count + CNT_W'(1);
                        end
                        pass <= 1'b0;
                        if (pass) begin
                            ff_q <= '{vec: vec_q, b: b_wv, s: s_wv};
                        end
                    end
                    if (last_c) begin
                        state_q <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        if (vec_valid) begin
                            overrun <= 1'b1;
                        end
                    end else if (vec_valid) begin
                        vec_q   <= vec_in;
                        state_q <= SETTLE;
                    end else begin
                        state_q <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                DONE: begin
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign first_fail_vec = ff_q.vec;
    assign first_fail_b   = ff_q.b;
    assign first_fail_s   = ff_q.s;

endmodule

// File: tb/tb_equiv_compare_monitor.sv
// Scoreboard bench for equiv_compare_monitor: a timestamp-based reference
// model pushes the expected result of every compare; a monitor pops and
// checks whenever vec_count advances.
module tb_equiv_compare_monitor;

    localparam int S  = 2;
    localparam int NV = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic       vec_valid = 1'b0;
    logic [3:0] vec_in = '0;
    logic [1:0] b_wv = '0;
    logic [1:0] s_wv = '0;
    logic       busy, done, pass, overrun;
    logic [7:0] vec_count, mismatch_count;
    logic [3:0] first_fail_vec;
    logic [1:0] first_fail_b, first_fail_s;

    equiv_compare_monitor #(
        .SETTLE_CYCLES (S),
        .NUM_VECTORS   (NV),
        .CNT_W         (8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .clear          (clear),
        .vec_valid      (vec_valid),
        .vec_in         (vec_in),
        .b_wv           (b_wv),
        .s_wv           (s_wv),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .overrun        (overrun),
        .vec_count      (vec_count),
        .mismatch_count (mismatch_count),
        .first_fail_vec (first_fail_vec),
        .first_fail_b   (first_fail_b),
        .first_fail_s   (first_fail_s)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int         cnt;
        int         mis;
        logic       pass;
        logic       ovr;
        logic       done;
        logic [3:0] fv;
        logic [1:0] fb;
        logic [1:0] fs;
    } exp_t;

    exp_t sb_q[$];

    // Reference model: results so far plus the one vector awaiting compare.
    int         m_cnt, m_mis;
    logic       m_pass, m_ovr, m_done;
    logic [3:0] m_fv;
    logic [1:0] m_fb, m_fs;
    bit         m_pend;
    int         m_pend_t;
    logic [3:0] m_pend_vec;
    bit         st_valid;
    int         st_t;
    logic [3:0] st_vec;
    int         clr_t = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_mis = 0; m_pass = 1'b1; m_ovr = 1'b0; m_done = 1'b0;
        m_fv = '0; m_fb = '0; m_fs = '0;
        m_pend = 0; st_valid = 0;
    endtask

    // Apply the rules for clock edge e: a vector strobed at edge t is compared
    // at edge t+S+1 with the UUT outputs present there, unless a newer strobe
    // lands within t+1..t+S. Once NV compares are done, strobes are ignored,
    // except one coinciding with the final compare, which counts as dropped.
    task automatic model_tick(input int e);
        exp_t r;
        bit   retired;
        retired = 0;
        if (!rst_n || clr_t == e) begin
            model_reset();
            sb_q.delete();
            clr_t = -1;
            return;
        end
        if (m_pend && e == m_pend_t + S + 1) begin
            m_pend = 0;
            retired = 1;
            m_cnt++;
            if (b_wv !== s_wv) begin
                if (m_mis < 255) m_mis++;
                if (m_pass) begin
                    m_fv = m_pend_vec; m_fb = b_wv; m_fs = s_wv;
                end
                m_pass = 1'b0;
            end
            if (m_cnt == NV) m_done = 1'b1;
        end
        if (st_valid && st_t == e) begin
            st_valid = 0;
            if (m_done) begin
                if (retired) m_ovr = 1'b1;
            end else begin
                if (m_pend) m_ovr = 1'b1;
                m_pend = 1; m_pend_t = e; m_pend_vec = st_vec;
            end
        end
        if (retired) begin
            r.cnt = m_cnt; r.mis = m_mis; r.pass = m_pass; r.ovr = m_ovr;
            r.done = m_done; r.fv = m_fv; r.fb = m_fb; r.fs = m_fs;
            sb_q.push_back(r);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_tick(cyc);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) step();
    endtask

    task automatic strobe(input logic [3:0] v, input logic [1:0] b, input logic [1:0] s);
        vec_in = v; b_wv = b; s_wv = s; vec_valid = 1'b1;
        st_valid = 1; st_t = cyc + 1; st_vec = v;
        step();
        vec_valid = 1'b0;
    endtask

    task automatic send(input logic [3:0] v, input logic [1:0] b, input logic [1:0] s, input int gap);
        strobe(v, b, s);
        if (gap > 1) wait_cyc(gap - 1);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        clr_t = cyc + 1;
        step();
        clear = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_pass"}, 32'(pass), 1);
        chk({tag, "_ovr"}, 32'(overrun), 0);
        chk({tag, "_vcnt"}, 32'(vec_count), 0);
        chk({tag, "_mcnt"}, 32'(mismatch_count), 0);
        chk({tag, "_ffv"}, 32'(first_fail_vec), 0);
        chk({tag, "_ffb"}, 32'(first_fail_b), 0);
        chk({tag, "_ffs"}, 32'(first_fail_s), 0);
    endtask

    // Monitor: every advance of vec_count is one compare to score.
    logic [7:0] prev_cnt = '0;
    always @(negedge clk) begin
        exp_t r;
        if (rst_n && vec_count != prev_cnt && vec_count != 8'd0) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_unexpected: vec_count=%0d with nothing expected", vec_count);
            end else begin
                r = sb_q.pop_front();
                chk("sb_vcnt", 32'(vec_count), 32'(r.cnt));
                chk("sb_mcnt", 32'(mismatch_count), 32'(r.mis));
                chk("sb_pass", 32'(pass), 32'(r.pass));
                chk("sb_ovr", 32'(overrun), 32'(r.ovr));
                chk("sb_done", 32'(done), 32'(r.done));
                chk("sb_ffv", 32'(first_fail_vec), 32'(r.fv));
                chk("sb_ffb", 32'(first_fail_b), 32'(r.fb));
                chk("sb_ffs", 32'(first_fail_s), 32'(r.fs));
            end
        end
        prev_cnt = vec_count;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] v, v3;
        logic [1:0] b, b3;

        model_reset();
        wait_cyc(3);
        rst_n = 1'b1;
        step();
        check_reset("reset");

        // Ten identical vectors, spaced 5.
        for (int i = 1; i <= NV; i++) begin
            v = 4'($urandom_range(0, 15)); b = 2'($urandom_range(0, 3));
            send(v, b, b, 5);
        end
        wait_cyc(3);
        chk("clean_done", 32'(done), 1);
        chk("clean_pass", 32'(pass), 1);
        chk("clean_vcnt", 32'(vec_count), 10);
        chk("clean_mcnt", 32'(mismatch_count), 0);
        chk("clean_ovr", 32'(overrun), 0);

        // Mismatch injected on vectors 3 and 7.
        do_clear();
        check_reset("clear1");
        v3 = '0; b3 = '0;
        for (int i = 1; i <= NV; i++) begin
            v = 4'($urandom_range(0, 15)); b = 2'($urandom_range(0, 3));
            if (i == 3) begin v3 = v; b3 = b; end
            send(v, b, (i == 3 || i == 7) ? (b ^ 2'b01) : b, 5);
        end
        wait_cyc(3);
        chk("mis_mcnt", 32'(mismatch_count), 2);
        chk("mis_pass", 32'(pass), 0);
        chk("mis_ffv", 32'(first_fail_vec), 32'(v3));
        chk("mis_ffb", 32'(first_fail_b), 32'(b3));
        chk("mis_ffs", 32'(first_fail_s), 32'(b3 ^ 2'b01));

        // Strobe in DONE is ignored, then clear re-arms.
        send(4'h5, 2'b00, 2'b11, 6);
        chk("done_vcnt", 32'(vec_count), 10);
        chk("done_ovr", 32'(overrun), 0);
        chk("done_hold", 32'(done), 1);
        do_clear();
        check_reset("clear2");
        strobe(4'h9, 2'b10, 2'b10);
        chk("rearm_busy", 32'(busy), 1);
        wait_cyc(5);
        chk("rearm_vcnt", 32'(vec_count), 1);

        // Two strobes one cycle apart: first vector is dropped.
        do_clear();
        send(4'h3, 2'b01, 2'b01, 1);
        send(4'hC, 2'b10, 2'b00, 6);
        chk("ovr_flag", 32'(overrun), 1);
        chk("ovr_vcnt", 32'(vec_count), 1);
        chk("ovr_ffv", 32'(first_fail_vec), 32'(4'hC));

        // Strobe landing in the COMPARE cycle is legal.
        do_clear();
        send(4'h1, 2'b11, 2'b11, S + 1);
        send(4'h2, 2'b01, 2'b01, 6);
        chk("cmp_ovr", 32'(overrun), 0);
        chk("cmp_vcnt", 32'(vec_count), 2);

        // Async reset in the middle of SETTLE.
        do_clear();
        for (int i = 1; i <= 4; i++) begin
            b = 2'($urandom_range(0, 3));
            send(4'(i), b, (i == 2) ? ~b : b, 5);
        end
        chk("prerst_vcnt", 32'(vec_count), 4);
        chk("prerst_mcnt", 32'(mismatch_count), 1);
        strobe(4'hE, 2'b00, 2'b00);
        chk("prerst_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        check_reset("rst_async");
        step();
        rst_n = 1'b1;
        for (int i = 1; i <= NV; i++) begin
            b = 2'($urandom_range(0, 3));
            send(4'($urandom_range(0, 15)), b, b, 4);
        end
        wait_cyc(3);
        chk("rerun_pass", 32'(pass), 1);
        chk("rerun_done", 32'(done), 1);
        chk("rerun_vcnt", 32'(vec_count), 10);

        // Random spacing and random mismatches against the model.
        for (int r = 0; r < 3; r++) begin
            do_clear();
            for (int i = 0; i < 25; i++) begin
                b = 2'($urandom_range(0, 3));
                v = 4'($urandom_range(0, 15));
                send(v, b, ($urandom_range(0, 3) == 0) ? (b ^ 2'($urandom_range(1, 3))) : b,
                     int'($urandom_range(1, 6)));
            end
            wait_cyc(8);
            chk("rnd_vcnt", 32'(vec_count), 32'(m_cnt));
            chk("rnd_mcnt", 32'(mismatch_count), 32'(m_mis));
            chk("rnd_ovr", 32'(overrun), 32'(m_ovr));
            chk("rnd_done", 32'(done), 32'(m_done));
            chk("rnd_pass", 32'(pass), 32'(m_pass));
        end

        wait_cyc(2);
        chk("sb_drain", 32'(sb_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
